ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline, consuming the ID/EX pipeline register outputs and feeding the EX/MEM buffer. It contains:
- operand forwarding muxes
- the ALU
- branch target/decision logic
- an iterative multiply/divide unit with HI/LO registers

The mul/div unit stalls the front of the pipeline while it runs.

## Interface
- None; datapath fixed at 32 bits, mul/div iteration count fixed at 32.

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in, Branch_in  in  1 each  control from ID/EX
- ALUOp_in  in  2  00 add, 01 sub, 10 R-type (funct), 11 or
- pc_next_in, read_data1_in, read_data2_in, sign_ext_in  in  32 each  ID/EX data; funct = sign_ext_in[5:0], shamt = sign_ext_in[10:6]
- rs_in, rt_in, rd_in  in  5 each  register specifiers
- ex_mem_regwrite, mem_wb_regwrite  in  1  forwarding-source write enables
- ex_mem_rd, mem_wb_rd  in  5  forwarding-source destinations
- ex_mem_alu_result, mem_wb_data  in  32  forwarding-source values
- RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  out  1 each  control to EX/MEM
- alu_result  out  32  ALU or HI/LO result
- write_data  out  32  forwarded rt value (store data)
- write_reg  out  5  RegDst_in ? rd_in : rt_in
- branch_target  out  32  pc_next_in + (sign_ext_in << 2), mod 2^32
- zero  out  1  alu_result == 0
- branch_taken  out  1  Branch_in & zero
- stall  out  1  hold PC, IF/ID and ID/EX
- hi, lo  out  32  HI/LO registers

## Operation
- **Forwarding, operand A (rs):**
  - ex_mem_regwrite & ex_mem_rd!=0 & ex_mem_rd==rs_in → ex_mem_alu_result;
  - else the same test with mem_wb → mem_wb_data;
  - else read_data1_in.
  - Operand rt is resolved identically and yields write_data.
  - EX/MEM has priority over MEM/WB.
- **ALU operand B:** ALUSrc_in ? sign_ext_in : forwarded rt.
- **R-type funct decode:**
  - 0x20/0x21 add, 0x22/0x23 sub; no overflow trap.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x00 sll, 0x02 srl: forwarded rt shifted by shamt.
  - 0x10 mfhi, 0x12 mflo.
  - Any other funct → alu_result 0.
- **Mul/div issue:** ALUOp_in==10, funct 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- **Mul/div FSM, states IDLE, BUSY, DONE:**
  - IDLE: on issue, latch forwarded operands, op and sign flags; counter←0; go to BUSY.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes. After counter==31, apply sign correction, write HI/LO, go to DONE.
  - DONE: issue ignored; go to IDLE next cycle. This lets the stalled instruction leave EX without re-issuing.
- **Sign rules:**
  - Signed product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend sign (truncating division).
- **Mul/div results:**
  - mult/multu: HI = product[63:32], LO = product[31:0].
  - div/divu: LO = quotient, HI = remainder.
- **Divide by zero:** LO = 0xFFFFFFFF, HI = dividend; full latency still applies.
- **Stall:** stall = (IDLE & issue) | BUSY. While stall=1, RegWrite_out, MemRead_out and MemWrite_out are forced to 0 (bubble to EX/MEM).

## Timing
- **Combinational:** forwarding, ALU, branch and control outputs, within one cycle.
- **Mul/div latency:**
  - Issue cycle + 32 BUSY cycles = 33 cycles with stall=1.
  - The DONE cycle has stall=0; the instruction advances at the end of it.
  - HI/LO update on the BUSY→DONE edge.
  - An mfhi/mflo in the following cycle reads the new values.
- **Reset (asserted low, any time including mid-BUSY):**
  - FSM→IDLE, counter=0, HI=LO=0, stall=0.
  - Combinational outputs follow their inputs.
- **Simultaneous events:**
  - An issue in DONE is ignored.
  - A back-to-back mul/div issues one cycle after DONE, i.e. from IDLE.

## Test plan
- **Reset mid-operation:** reset low during BUSY cycle 10 → stall=0, hi=lo=0. After release, a new mult completes normally.
- **Forwarding priority:**
  - Setup: rs_in=5, ex_mem_rd=5 result 0x10, mem_wb_rd=5 data 0x20, read_data1_in=0x30, add with B=1.
  - Expected: alu_result=0x11.
  - With ex_mem_regwrite=0: 0x21.
  - With rs_in=ex_mem_rd=0: 0x31.
- **Signed multiply:** mult -3×7 → stall high exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; next-cycle mfhi → alu_result=0xFFFFFFFF.
- **Divide:**
  - div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 → lo=0xFFFFFFFF, hi=7, same 33-cycle stall.
- **Branch:** Branch_in=1, ALUOp_in=01, equal operands, pc_next_in=0x100, sign_ext_in=0xFFFFFFFF → branch_target=0xFC, zero=1, branch_taken=1.
- **Compare and bubble:**
  - slt with 0xFFFFFFFF vs 1 → 1; sltu → 0.
  - During the mul stall, RegWrite_out=MemWrite_out=0 regardless of inputs.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage; the master side drives ID/EX
// fields and forwarding sources, the slave side (ex_stage) drives EX/MEM results.
// Purely wiring, no storage.
interface ex_stage_if;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic        RegDst_in, ALUSrc_in, Branch_in;
    logic [1:0]  ALUOp_in;
    logic [31:0] pc_next_in, read_data1_in, read_data2_in, sign_ext_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        ex_mem_regwrite, mem_wb_regwrite;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_alu_result, mem_wb_data;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [31:0] alu_result, write_data, branch_target;
    logic [4:0]  write_reg;
    logic        zero, branch_taken, stall;
    logic [31:0] hi, lo;

    modport master (
        output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in,
               Branch_in, ALUOp_in, pc_next_in, read_data1_in, read_data2_in, sign_ext_in,
               rs_in, rt_in, rd_in, ex_mem_regwrite, mem_wb_regwrite, ex_mem_rd, mem_wb_rd,
               ex_mem_alu_result, mem_wb_data,
        input  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, alu_result, write_data,
               write_reg, branch_target, zero, branch_taken, stall, hi, lo
    );

    modport slave (
        input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUSrc_in,
               Branch_in, ALUOp_in, pc_next_in, read_data1_in, read_data2_in, sign_ext_in,
               rs_in, rt_in, rd_in, ex_mem_regwrite, mem_wb_regwrite, ex_mem_rd, mem_wb_rd,
               ex_mem_alu_result, mem_wb_data,
        output RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, alu_result, write_data,
               write_reg, branch_target, zero, branch_taken, stall, hi, lo
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, branch resolve, iterative mul/div with HI/LO.
// Latency: ALU/branch combinational; mul/div holds stall for 33 cycles, HI/LO valid in DONE.
// Backpressure: stall freezes the front end and turns EX/MEM writes into a bubble.
module ex_stage (
    input  logic     clk,
    input  logic     reset,
    ex_stage_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd, dividend, hi_q, lo_q;
    logic        md_div, neg_res, neg_rem;

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] fwd_a, fwd_b, op_b, alu_res, mag_a, mag_b;
    logic        issue, sgn;

    assign funct = bus.sign_ext_in[5:0];
    assign shamt = bus.sign_ext_in[10:6];

    // EX/MEM result is newer than MEM/WB, so it wins when both match
    always_comb begin
        fwd_a = bus.read_data1_in;
        if (bus.ex_mem_regwrite && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == bus.rs_in)
            fwd_a = bus.ex_mem_alu_result;
        else if (bus.mem_wb_regwrite && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == bus.rs_in)
            fwd_a = bus.mem_wb_data;
        fwd_b = bus.read_data2_in;
        if (bus.ex_mem_regwrite && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == bus.rt_in)
            fwd_b = bus.ex_mem_alu_result;
        else if (bus.mem_wb_regwrite && bus.mem_wb_rd != 5'd0 && bus.mem_wb_rd == bus.rt_in)
            fwd_b = bus.mem_wb_data;
    end

    assign op_b = bus.ALUSrc_in ? bus.sign_ext_in : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        case (bus.ALUOp_in)
            2'b00: alu_res = fwd_a + op_b;
            2'b01: alu_res = fwd_a - op_b;
            2'b11: alu_res = fwd_a | op_b;
            default: begin
                case (funct)
                    6'h20, 6'h21: alu_res = fwd_a + op_b;
                    6'h22, 6'h23: alu_res = fwd_a - op_b;
                    6'h24: alu_res = fwd_a & op_b;
                    6'h25: alu_res = fwd_a | op_b;
                    6'h26: alu_res = fwd_a ^ op_b;
                    6'h27: alu_res = ~(fwd_a | op_b);
                    6'h2A: alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
                    6'h2B: alu_res = {31'd0, fwd_a < op_b};
                    6'h00: alu_res = fwd_b << shamt;
                    6'h02: alu_res = fwd_b >> shamt;
                    6'h10: alu_res = hi_q;
                    6'h12: alu_res = lo_q;
                    default: alu_res = 32'd0;
                endcase
            end
        endcase
    end

    // funct 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
    assign issue = (bus.ALUOp_in == 2'b10) && (funct[5:2] == 4'b0110);
    assign sgn   = ~funct[0];
    assign mag_a = (sgn && fwd_a[31]) ? (32'd0 - fwd_a) : fwd_a;
    assign mag_b = (sgn && fwd_b[31]) ? (32'd0 - fwd_b) : fwd_b;

    // Shared accumulator: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}
    logic [32:0] mul_sum, div_shift;
    logic [63:0] mul_next, div_next, step, prod;
    logic        div_ge;

    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};
    assign div_shift = acc[63:31];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_next  = div_ge ? {div_shift[31:0] - opnd, acc[30:0], 1'b1}
                              : {div_shift[31:0], acc[30:0], 1'b0};
    assign step      = md_div ? div_next : mul_next;
    assign prod      = neg_res ? (64'd0 - step) : step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            dividend <= 32'd0;
            md_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: if (issue) begin
                    acc      <= {32'd0, mag_a};
                    opnd     <= mag_b;
                    dividend <= fwd_a;
                    md_div   <= funct[1];
                    neg_res  <= sgn & (fwd_a[31] ^ fwd_b[31]);
                    neg_rem  <= sgn & fwd_a[31];
                    cnt      <= 5'd0;
                    state    <= ST_BUSY;
                end
                ST_BUSY: begin
                    acc <= step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_DONE;
                        if (!md_div) begin
                            hi_q <= prod[63:32];
                            lo_q <= prod[31:0];
                        end else if (opnd == 32'd0) begin
                            hi_q <= dividend;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= neg_rem ? (32'd0 - step[63:32]) : step[63:32];
                            lo_q <= neg_res ? (32'd0 - step[31:0]) : step[31:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset also masks the issue term so the front end is never held during reset
    assign bus.stall         = reset && (((state == ST_IDLE) && issue) || (state == ST_BUSY));
    assign bus.RegWrite_out  = bus.RegWrite_in & ~bus.stall;
    assign bus.MemRead_out   = bus.MemRead_in & ~bus.stall;
    assign bus.MemWrite_out  = bus.MemWrite_in & ~bus.stall;
    assign bus.MemtoReg_out  = bus.MemtoReg_in;
    assign bus.alu_result    = alu_res;
    assign bus.write_data    = fwd_b;
    assign bus.write_reg     = bus.RegDst_in ? bus.rd_in : bus.rt_in;
    assign bus.branch_target = bus.pc_next_in + {bus.sign_ext_in[29:0], 2'b00};
    assign bus.zero          = (alu_res == 32'd0);
    assign bus.branch_taken  = bus.Branch_in & bus.zero;
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU decode, branch, mul/div timing and reset.
module tb_ex_stage;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.RegWrite_in = 0; bus.MemtoReg_in = 0; bus.MemRead_in = 0; bus.MemWrite_in = 0;
        bus.RegDst_in = 0; bus.ALUSrc_in = 0; bus.Branch_in = 0; bus.ALUOp_in = 2'b00;
        bus.pc_next_in = 0; bus.read_data1_in = 0; bus.read_data2_in = 0; bus.sign_ext_in = 0;
        bus.rs_in = 0; bus.rt_in = 0; bus.rd_in = 0;
        bus.ex_mem_regwrite = 0; bus.mem_wb_regwrite = 0; bus.ex_mem_rd = 0; bus.mem_wb_rd = 0;
        bus.ex_mem_alu_result = 0; bus.mem_wb_data = 0;
    endtask

    task automatic set_rtype(input logic [31:0] a, input logic [31:0] b, input logic [31:0] f);
        clear_inputs();
        bus.ALUOp_in = 2'b10; bus.read_data1_in = a; bus.read_data2_in = b; bus.sign_ext_in = f;
        #1;
    endtask

    // Issues a mul/div and counts stalled cycles; returns positioned in the DONE cycle
    task automatic run_md(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn,
                          output int cycles);
        clear_inputs();
        bus.ALUOp_in = 2'b10; bus.sign_ext_in = {26'd0, fn};
        bus.read_data1_in = a; bus.read_data2_in = b;
        bus.RegWrite_in = 1; bus.MemWrite_in = 1; bus.MemRead_in = 1;
        cycles = 0;
        #1;
        while (bus.stall && cycles < 200) begin
            if (cycles == 5) begin
                check("bubble_regwrite", bus.RegWrite_out, 0);
                check("bubble_memwrite", bus.MemWrite_out, 0);
            end
            cycles++;
            @(negedge clk); #1;
        end
        bus.sign_ext_in = 32'h10;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        reset = 1'b0;
        #12;
        check("rst_stall", bus.stall, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b1;

        // forwarding priority
        @(negedge clk);
        bus.rs_in = 5; bus.ex_mem_regwrite = 1; bus.ex_mem_rd = 5; bus.ex_mem_alu_result = 32'h10;
        bus.mem_wb_regwrite = 1; bus.mem_wb_rd = 5; bus.mem_wb_data = 32'h20;
        bus.read_data1_in = 32'h30; bus.ALUOp_in = 2'b00; bus.ALUSrc_in = 1; bus.sign_ext_in = 1;
        #1 check("fwd_exmem", bus.alu_result, 32'h11);
        bus.ex_mem_regwrite = 0;
        #1 check("fwd_memwb", bus.alu_result, 32'h21);
        bus.ex_mem_regwrite = 1; bus.rs_in = 0; bus.ex_mem_rd = 0;
        #1 check("fwd_r0", bus.alu_result, 32'h31);
        bus.rt_in = 5; bus.read_data2_in = 32'h77;
        #1 check("fwd_rt_memwb", bus.write_data, 32'h20);
        bus.RegDst_in = 1; bus.rd_in = 9; bus.rt_in = 3;
        #1 check("write_reg_rd", bus.write_reg, 9);
        check("write_data_plain", bus.write_data, 32'h77);

        // branch
        clear_inputs();
        bus.Branch_in = 1; bus.ALUOp_in = 2'b01; bus.read_data1_in = 32'h1234;
        bus.read_data2_in = 32'h1234; bus.pc_next_in = 32'h100; bus.sign_ext_in = 32'hFFFF_FFFF;
        #1;
        check("br_target", bus.branch_target, 32'hFC);
        check("br_zero", bus.zero, 1);
        check("br_taken", bus.branch_taken, 1);
        bus.read_data2_in = 32'h1235;
        #1 check("br_not_taken", bus.branch_taken, 0);

        // R-type decode
        set_rtype(32'hFFFF_FFFF, 32'h1, 32'h2A); check("slt", bus.alu_result, 1);
        set_rtype(32'hFFFF_FFFF, 32'h1, 32'h2B); check("sltu", bus.alu_result, 0);
        set_rtype(32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h27); check("nor", bus.alu_result, 32'h000F_F000);
        set_rtype(32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h26); check("xor", bus.alu_result, 32'hFF00_0FF0);
        set_rtype(32'h5, 32'h8, 32'h23); check("subu", bus.alu_result, 32'hFFFF_FFFD);
        set_rtype(32'h0, 32'h3, 32'h100); check("sll", bus.alu_result, 32'h30);
        set_rtype(32'h0, 32'h8000_0000, 32'h102); check("srl", bus.alu_result, 32'h0800_0000);
        set_rtype(32'h1, 32'h1, 32'h3F); check("bad_funct", bus.alu_result, 0);

        // signed multiply
        @(negedge clk);
        run_md(32'hFFFF_FFFD, 32'd7, 6'h18, cyc);
        check("mult_cycles", cyc, 33);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFEB);
        @(negedge clk); #1;
        check("mfhi", bus.alu_result, 32'hFFFF_FFFF);
        bus.sign_ext_in = 32'h12;
        #1 check("mflo", bus.alu_result, 32'hFFFF_FFEB);

        @(negedge clk);
        run_md(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h19, cyc);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h1);

        @(negedge clk);
        run_md(32'hFFFF_FFF9, 32'd2, 6'h1A, cyc);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        @(negedge clk);
        run_md(32'd7, 32'd0, 6'h1B, cyc);
        check("divz_cycles", cyc, 33);
        check("divz_lo", bus.lo, 32'hFFFF_FFFF);
        check("divz_hi", bus.hi, 32'd7);

        // reset during BUSY
        @(negedge clk);
        clear_inputs();
        bus.ALUOp_in = 2'b10; bus.sign_ext_in = 32'h18;
        bus.read_data1_in = 32'd6; bus.read_data2_in = 32'd7;
        repeat (10) @(negedge clk);
        #1 check("busy_stall", bus.stall, 1);
        reset = 1'b0;
        #1;
        check("midrst_stall", bus.stall, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b1;
        run_md(32'd6, 32'd7, 6'h18, cyc);
        check("post_rst_cycles", cyc, 33);
        check("post_rst_lo", bus.lo, 32'd42);
        check("post_rst_hi", bus.hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
